axi_st_patgen_f2h_top: RTL and testbench
========================================

// Module: axi_st_patgen_f2h_top
// PURPOSE
//  AXIST full-to-half pattern generator; transmit end of the dual half2full checker link.
//  Builds 512-bit LFSR pattern words and sends each as two 256-bit AXI-ST beats, low half first.
//  Mirrors each word's two 40-bit lane seeds onto patgen_din/patgen_din_wr for the checker's expected-data FIFO.
//  One clock domain (wrclk).
// PARAMETERS
//  LANE0_SEED  40'h00DEADBEEF  lane0 LFSR reset value; if 0, 40'h1 is loaded instead
//  LANE1_SEED  40'h123456789A  lane1 LFSR reset value; if 0, 40'h1 is loaded instead
// PORTS
//  wrclk            in   1    clock
//  rst              in   1    asynchronous active-high reset
//  patgen_en        in   1    start request; rising edge starts a counted run
//  patgen_cnt       in   9    number of 512-bit words per run; latched at start
//  cntuspatt_en     in   1    continuous mode; rising edge starts an unbounded run
//  chkr_fifo_full   in   1    checker expected-data FIFO full; stalls word generation
//  axist_tready     in   1    AXI-ST ready from the receiver
//  axist_valid      out  1    AXI-ST valid
//  axist_tx_data    out  256  AXI-ST data beat
//  patgen_din       out  80   {lane1,lane0} for the current word
//  patgen_din_wr    out  1    one-cycle write strobe for patgen_din
//  patgen_busy      out  1    high from run start until DONE is entered
//  patgen_done      out  1    one-cycle pulse when a run completes
//  patgen_sent_cnt  out  9    words fully sent in this run; saturates at 9'h1FF
// BEHAVIOUR
//  Reset: every output is 0; FSM is IDLE; LFSRs load their seeds; edge-detect registers are cleared.
//  Reset mid-run aborts immediately: valid drops with no beat completed, no done pulse.
//  Start: patgen_en and cntuspatt_en are registered once; rising edges are detected on the registered copies.
//   Either edge in IDLE starts a run one cycle later. Start edges are ignored outside IDLE.
//  Run start: patgen_cnt is latched, patgen_sent_cnt clears, and patgen_busy rises.
//   A counted run with latched cnt 0 goes straight to DONE: no beats, no din_wr.
//  Word build:
//   lane L (40b) gives half H: H[40i+39:40i] = L for i = 0..5, and H[255:240] = L[15:0].
//   lo half uses lane0 and hi half uses lane1.
//  LFSR: 40-bit Fibonacci per lane. Shift left; bit0 = b39^b37^b20^b18.
//   Steps exactly once per word (in LOAD), after the lane values are captured.
//  FSM states:
//   IDLE:    valid=0. Start edge -> LOAD, or -> DONE if counted run with cnt 0.
//   LOAD:    if chkr_fifo_full, wait in LOAD. Else capture lanes into the word register,
//            pulse patgen_din_wr with {lane1,lane0}, step both LFSRs -> SEND_LO.
//   SEND_LO: valid=1, data=lo half. On valid&tready -> SEND_HI.
//   SEND_HI: valid=1, data=hi half. On valid&tready, patgen_sent_cnt+1, then:
//            counted run and sent_cnt+1 == latched cnt -> DONE;
//            continuous run and cntuspatt_en_r low -> DONE;
//            otherwise -> LOAD.
//   DONE:    patgen_done=1 for one cycle, busy=0 -> IDLE.
//  Handshake:
//   - valid never depends on tready.
//   - while valid&!tready, valid and data are held stable; no beat is dropped or repeated.
//   - valid stays 1 from SEND_LO entry until the hi beat handshakes.
//  Throughput: 2 beats per 3 cycles with tready held high. First beat appears 2 cycles after the start edge is registered.
//  Continuous mode: deasserting cntuspatt_en mid-word always finishes that word (both beats) before DONE.
//  Precedence: cntuspatt_en_r high at the start edge selects continuous mode; a simultaneous patgen_en edge is ignored.
//  Expected-data ordering: every word produces exactly one din_wr, issued before its lo beat.
//  Counters:
//   - latched count is 9 bits, max 511 words;
//   - patgen_sent_cnt saturates at 9'h1FF in continuous mode and the run continues.
// TESTING
//  1. patgen_cnt=3, edge on patgen_en, tready=1 -> 3 din_wr pulses, 6 beats lo/hi alternating,
//     done pulse once, sent_cnt=3. Beat0[39:0]=40'h00DEADBEEF.
//  2. cnt=2, tready toggled pseudo-randomly -> data/valid stable during every stall, exactly 4 handshakes, done pulse once.
//  3. cnt=0, edge on patgen_en -> done pulses, no valid, no din_wr, busy high for at most 2 cycles.
//  4. cnt=4, chkr_fifo_full forced high at word 2 for 10 cycles -> stuck in LOAD, valid=0, no din_wr;
//     resumes on release, 4 words in total.
//  5. cntuspatt_en high for 20 cycles then low mid-hi-beat stall -> current word completes, then done;
//     sent_cnt equals number of din_wr pulses.
//  6. rst asserted during SEND_HI stall -> valid=0 same cycle, sent_cnt=0, busy=0.
//     Next run restarts from seeds (beat0 matches scenario 1).

Source files
------------

// File: rtl/axi_st_patgen_f2h_top.sv
// AXI-ST full-to-half pattern generator.
// Builds 512-bit LFSR pattern words and sends each one as two 256-bit beats,
// low half first. Each word's lane seeds are also written to the checker's
// expected-data FIFO before the word's low beat handshakes.
module axi_st_patgen_f2h_top #(
  parameter logic [39:0] LANE0_SEED = 40'h00DEADBEEF,
  parameter logic [39:0] LANE1_SEED = 40'h123456789A
) (
  input  logic         wrclk,
  input  logic         rst,
  input  logic         patgen_en,
  input  logic [8:0]   patgen_cnt,
  input  logic         cntuspatt_en,
  input  logic         chkr_fifo_full,
  input  logic         axist_tready,
  output logic         axist_valid,
  output logic [255:0] axist_tx_data,
  output logic [79:0]  patgen_din,
  output logic         patgen_din_wr,
  output logic         patgen_busy,
  output logic         patgen_done,
  output logic [8:0]   patgen_sent_cnt
);

  localparam int unsigned LANE_W = 40;
  localparam int unsigned HALF_W = 256;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned REPS   = 6;

  // A zero seed would lock the LFSR at zero, so it is replaced with 1.
  localparam logic [LANE_W-1:0] SEED0 = (LANE0_SEED == '0) ? LANE_W'(1) : LANE0_SEED;
  localparam logic [LANE_W-1:0] SEED1 = (LANE1_SEED == '0) ? LANE_W'(1) : LANE1_SEED;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Replicate a 40-bit lane across a 256-bit half; the top 16 bits take lane[15:0].
  function automatic logic [HALF_W-1:0] build_half(input logic [LANE_W-1:0] lane);
    logic [HALF_W-1:0] h;
    h = '0;
    for (int i = 0; i < int'(REPS); i++) begin
      h[LANE_W*i +: LANE_W] = lane;
    end
    h[HALF_W-1 -: 16] = lane[15:0];
    return h;
  endfunction

  // Fibonacci step: shift left, feedback from taps 39/37/20/18.
  function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] l);
    return {l[LANE_W-2:0], l[39] ^ l[37] ^ l[20] ^ l[18]};
  endfunction

  state_t              state_q, state_d;
  logic                en_r_q, en_rr_q, cen_r_q, cen_rr_q;
  logic                cont_q, cont_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [LANE_W-1:0]   lfsr0_q, lfsr0_d, lfsr1_q, lfsr1_d;
  logic [LANE_W-1:0]   hi_lane_q, hi_lane_d;
  logic                valid_q, valid_d;
  logic [HALF_W-1:0]   data_q, data_d;
  logic [2*LANE_W-1:0] din_q, din_d;
  logic                din_wr_q, din_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_c;
  logic                hs_c;

  assign start_c = (en_r_q & ~en_rr_q) | (cen_r_q & ~cen_rr_q);
  assign hs_c    = valid_q & axist_tready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    cnt_d     = cnt_q;
    sent_d    = sent_q;
    lfsr0_d   = lfsr0_q;
    lfsr1_d   = lfsr1_q;
    hi_lane_d = hi_lane_q;
    data_d    = data_q;
    din_d     = din_q;
    din_wr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          cont_d = cen_r_q;
          cnt_d  = patgen_cnt;
          sent_d = '0;
          if (!cen_r_q && (patgen_cnt == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (!chkr_fifo_full) begin
          hi_lane_d = lfsr1_q;
          data_d    = build_half(lfsr0_q);
          din_d     = {lfsr1_q, lfsr0_q};
          din_wr_d  = 1'b1;
          lfsr0_d   = lfsr_step(lfsr0_q);
          lfsr1_d   = lfsr_step(lfsr1_q);
          state_d   = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (hs_c) begin
          data_d  = build_half(hi_lane_q);
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (hs_c) begin
          sent_d = (sent_q == '1) ? sent_q : sent_q + CNT_W'(1);
          if (!cont_q && ((10'({1'b0, sent_q}) + 10'd1) == 10'({1'b0, cnt_q}))) begin
            state_d = ST_DONE;
          end else if (cont_q && !cen_r_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_SEND_LO) || (state_d == ST_SEND_HI);
    busy_d  = (state_d == ST_LOAD) || valid_d;
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      en_r_q    <= 1'b0;
      en_rr_q   <= 1'b0;
      cen_r_q   <= 1'b0;
      cen_rr_q  <= 1'b0;
      cont_q    <= 1'b0;
      cnt_q     <= '0;
      sent_q    <= '0;
      lfsr0_q   <= SEED0;
      lfsr1_q   <= SEED1;
      hi_lane_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      din_q     <= '0;
      din_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_r_q    <= patgen_en;
      en_rr_q   <= en_r_q;
      cen_r_q   <= cntuspatt_en;
      cen_rr_q  <= cen_r_q;
      cont_q    <= cont_d;
      cnt_q     <= cnt_d;
      sent_q    <= sent_d;
      lfsr0_q   <= lfsr0_d;
      lfsr1_q   <= lfsr1_d;
      hi_lane_q <= hi_lane_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      din_q     <= din_d;
      din_wr_q  <= din_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign axist_valid     = valid_q;
  assign axist_tx_data   = data_q;
  assign patgen_din      = din_q;
  assign patgen_din_wr   = din_wr_q;
  assign patgen_busy     = busy_q;
  assign patgen_done     = done_q;
  assign patgen_sent_cnt = sent_q;

endmodule

// File: tb/tb_axi_st_patgen_f2h_top.sv
// Self-checking bench for axi_st_patgen_f2h_top: random ready/stall stimulus
// against a queue-based model of the expected word stream.
module tb_axi_st_patgen_f2h_top;

  localparam logic [39:0] SEED0 = 40'h00DEADBEEF;
  localparam logic [39:0] SEED1 = 40'h123456789A;

  logic         wrclk = 1'b0;
  logic         rst;
  logic         patgen_en;
  logic [8:0]   patgen_cnt;
  logic         cntuspatt_en;
  logic         chkr_fifo_full;
  logic         axist_tready;
  logic         axist_valid;
  logic [255:0] axist_tx_data;
  logic [79:0]  patgen_din;
  logic         patgen_din_wr;
  logic         patgen_busy;
  logic         patgen_done;
  logic [8:0]   patgen_sent_cnt;

  axi_st_patgen_f2h_top dut (
    .wrclk           (wrclk),
    .rst             (rst),
    .patgen_en       (patgen_en),
    .patgen_cnt      (patgen_cnt),
    .cntuspatt_en    (cntuspatt_en),
    .chkr_fifo_full  (chkr_fifo_full),
    .axist_tready    (axist_tready),
    .axist_valid     (axist_valid),
    .axist_tx_data   (axist_tx_data),
    .patgen_din      (patgen_din),
    .patgen_din_wr   (patgen_din_wr),
    .patgen_busy     (patgen_busy),
    .patgen_done     (patgen_done),
    .patgen_sent_cnt (patgen_sent_cnt)
  );

  always #5 wrclk = ~wrclk;

  int           n_checks;
  int           n_pass;
  logic [39:0]  ref0, ref1;
  logic [255:0] exp_q[$];
  int           din_cnt, beat_cnt, done_cnt, valid_cyc, busy_cyc;
  logic         prev_stall;
  logic [255:0] prev_data;
  logic [255:0] first_data;
  logic [255:0] exp_beat;
  bit           found;

  function automatic logic [39:0] lfsr_next(input logic [39:0] l);
    logic fb;
    fb = l[39] ^ l[37] ^ l[20] ^ l[18];
    return {l[38:0], fb};
  endfunction

  function automatic logic [255:0] expand(input logic [39:0] l);
    logic [255:0] h;
    for (int i = 0; i < 6; i++) h[40*i +: 40] = l;
    h[255:240] = l[15:0];
    return h;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    ref0 = SEED0;
    ref1 = SEED1;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic clear_stats();
    din_cnt = 0; beat_cnt = 0; done_cnt = 0; valid_cyc = 0; busy_cyc = 0;
    first_data = '0;
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge wrclk);
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 256'(axist_valid), 256'(1));
        check("hold_data", axist_tx_data, prev_data);
      end
      if (patgen_din_wr) begin
        check("din", 256'(patgen_din), 256'({ref1, ref0}));
        exp_q.push_back(expand(ref0));
        exp_q.push_back(expand(ref1));
        ref0 = lfsr_next(ref0);
        ref1 = lfsr_next(ref1);
        din_cnt++;
      end
      if (axist_valid) begin
        valid_cyc++;
        if (axist_tready) begin
          if (beat_cnt == 0) first_data = axist_tx_data;
          if (exp_q.size() == 0) begin
            check("beat_before_din", 256'(0), 256'(1));
          end else begin
            exp_beat = exp_q.pop_front();
            check("beat", axist_tx_data, exp_beat);
          end
          beat_cnt++;
        end
      end
      if (patgen_busy) busy_cyc++;
      if (patgen_done) done_cnt++;
      prev_stall = axist_valid && !axist_tready;
      prev_data  = axist_tx_data;
    end
    @(posedge wrclk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (rnd_ready) axist_tready = 1'($urandom_range(0, 1));
      tick();
    end
    if (done_cnt == 0) check("done_timeout", 256'(0), 256'(1));
    axist_tready = 1'b1;
    tick();
  endtask

  // Random ready until the hi beat is pending, then stall it.
  task automatic stall_on_hi();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (axist_valid && (beat_cnt % 2 == 1)) begin
        axist_tready = 1'b0;
        found = 1'b1;
        break;
      end
      axist_tready = 1'($urandom_range(0, 1));
    end
    check("hi_stall_found", 256'(found), 256'(1));
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; patgen_en = 1'b0; patgen_cnt = '0; cntuspatt_en = 1'b0;
    chkr_fifo_full = 1'b0; axist_tready = 1'b0;
    clear_stats();
    model_reset();
    repeat (3) @(posedge wrclk);
    #1;
    check("rst_valid", 256'(axist_valid), 256'(0));
    check("rst_data", axist_tx_data, 256'(0));
    check("rst_din", 256'(patgen_din), 256'(0));
    check("rst_din_wr", 256'(patgen_din_wr), 256'(0));
    check("rst_busy", 256'(patgen_busy), 256'(0));
    check("rst_done", 256'(patgen_done), 256'(0));
    check("rst_sent", 256'(patgen_sent_cnt), 256'(0));
    rst = 1'b0;
    tick();

    // Counted run of 3 words with ready held high; first-beat latency.
    clear_stats();
    patgen_cnt = 9'd3; axist_tready = 1'b1; patgen_en = 1'b1;
    tick();
    tick();
    check("s1_lat_load", 256'(axist_valid), 256'(0));
    tick();
    check("s1_lat_first", 256'(axist_valid), 256'(1));
    patgen_en = 1'b0;
    wait_done(100, 1'b0);
    check("s1_din_cnt", 256'(din_cnt), 256'(3));
    check("s1_beats", 256'(beat_cnt), 256'(6));
    check("s1_valid_cyc", 256'(valid_cyc), 256'(6));
    check("s1_done", 256'(done_cnt), 256'(1));
    check("s1_sent", 256'(patgen_sent_cnt), 256'(3));
    check("s1_beat0", 256'(first_data[39:0]), 256'(40'h00DEADBEEF));
    check("s1_busy_end", 256'(patgen_busy), 256'(0));

    // Counted run of 2 words with random backpressure.
    clear_stats();
    patgen_cnt = 9'd2; patgen_en = 1'b1;
    tick();
    patgen_en = 1'b0;
    wait_done(400, 1'b1);
    check("s2_beats", 256'(beat_cnt), 256'(4));
    check("s2_din_cnt", 256'(din_cnt), 256'(2));
    check("s2_done", 256'(done_cnt), 256'(1));
    check("s2_sent", 256'(patgen_sent_cnt), 256'(2));

    // Zero-length counted run.
    clear_stats();
    patgen_cnt = 9'd0; patgen_en = 1'b1;
    tick();
    patgen_en = 1'b0;
    wait_done(20, 1'b0);
    tick();
    check("s3_done", 256'(done_cnt), 256'(1));
    check("s3_din_cnt", 256'(din_cnt), 256'(0));
    check("s3_valid_cyc", 256'(valid_cyc), 256'(0));
    check("s3_busy_le2", 256'(busy_cyc <= 2), 256'(1));

    // Checker FIFO full stalls the second word in LOAD.
    clear_stats();
    patgen_cnt = 9'd4; axist_tready = 1'b1; patgen_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      patgen_en = 1'b0;
      if (din_cnt == 1) break;
    end
    chkr_fifo_full = 1'b1;
    repeat (10) tick();
    check("s4_stall_din", 256'(din_cnt), 256'(1));
    check("s4_stall_beats", 256'(beat_cnt), 256'(2));
    check("s4_stall_valid", 256'(axist_valid), 256'(0));
    check("s4_stall_busy", 256'(patgen_busy), 256'(1));
    chkr_fifo_full = 1'b0;
    wait_done(100, 1'b0);
    check("s4_din_cnt", 256'(din_cnt), 256'(4));
    check("s4_beats", 256'(beat_cnt), 256'(8));
    check("s4_sent", 256'(patgen_sent_cnt), 256'(4));
    check("s4_done", 256'(done_cnt), 256'(1));

    // Continuous run, stopped while the hi beat is stalled.
    clear_stats();
    cntuspatt_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      axist_tready = 1'($urandom_range(0, 1));
      tick();
    end
    stall_on_hi();
    cntuspatt_en = 1'b0;
    repeat (3) tick();
    check("s5_still_valid", 256'(axist_valid), 256'(1));
    check("s5_no_early_done", 256'(done_cnt), 256'(0));
    axist_tready = 1'b1;
    wait_done(50, 1'b0);
    check("s5_done", 256'(done_cnt), 256'(1));
    check("s5_sent_eq_din", 256'(patgen_sent_cnt), 256'(din_cnt));
    check("s5_beats", 256'(beat_cnt), 256'(2 * din_cnt));
    check("s5_q_empty", 256'(exp_q.size()), 256'(0));

    // Reset during a hi-beat stall, then a fresh run from the seeds.
    clear_stats();
    patgen_cnt = 9'd3; patgen_en = 1'b1;
    tick();
    patgen_en = 1'b0;
    stall_on_hi();
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("s6_valid", 256'(axist_valid), 256'(0));
    check("s6_sent", 256'(patgen_sent_cnt), 256'(0));
    check("s6_busy", 256'(patgen_busy), 256'(0));
    check("s6_done", 256'(patgen_done), 256'(0));
    model_reset();
    tick();
    rst = 1'b0;
    axist_tready = 1'b1;
    tick();
    clear_stats();
    patgen_en = 1'b1;
    tick();
    patgen_en = 1'b0;
    wait_done(100, 1'b0);
    check("s6_beat0", 256'(first_data[39:0]), 256'(40'h00DEADBEEF));
    check("s6_beats", 256'(beat_cnt), 256'(6));
    check("s6_din_cnt", 256'(din_cnt), 256'(3));
    check("s6_run_done", 256'(done_cnt), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
